// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose
//   Single-port data-memory responder. It accepts one load/store request at a
//   time, waits a fixed number of cycles, then presents a response that is
//   held until the requester takes it. Byte, half and word accesses are
//   supported on a 32-bit word array. Misaligned or illegal accesses report
//   an error and never modify memory.
//
// Handshake semantics (both channels)
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The request side is ready only in IDLE. A response, once valid, keeps
//   rsp_valid, rsp_rdata and rsp_err stable until the edge with rsp_ready = 1.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   req_valid     request present
//   req_ready     responder can accept a request (IDLE only)
//   req_write     1 = store, 0 = load
//   req_addr      byte address; bits above ADDR_WIDTH+1 are ignored (wrap)
//   req_wdata     store data, right-aligned
//   req_type      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  1 = zero-extend loads, 0 = sign-extend loads
//   rsp_valid     response present
//   rsp_ready     requester accepts the response
//   rsp_rdata     load result (0 for stores and errors)
//   rsp_err       misaligned or illegal access
//   dbg_state     current FSM state (IDLE=0, WAIT=1, RESP=2)
//
// The lane layout (four byte lanes selected by addr[1:0]) assumes
// DATA_WIDTH = 32.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_type,
    input  logic                  req_unsigned,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BA_W  = ADDR_WIDTH + 2;   // byte-address bits actually used

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Counter reload; the WAIT state is never entered when WAIT_CYCLES = 0.
    localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    // State and latched request
    logic [1:0]            state_q,    state_d;
    logic [3:0]            cnt_q,      cnt_d;
    logic                  write_q,    write_d;
    logic [BA_W-1:0]       addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [1:0]            type_q,     type_d;
    logic                  unsigned_q, unsigned_d;

    // Response registers
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    // Storage (not reset)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Operand view: in IDLE the live inputs (only used when WAIT_CYCLES = 0
    // and the response is produced on the acceptance edge), else the latches.
    logic                  op_write;
    logic [BA_W-1:0]       op_addr;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [1:0]            op_type;
    logic                  op_unsigned;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  op_err;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  enter_resp;
    logic                  mem_we;

    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:BA_W];

    // ---------------------------------------------------------------------
    // Access decode: alignment, load extraction, store lane placement
    // ---------------------------------------------------------------------
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_write    = req_write;
            op_addr     = req_addr[BA_W-1:0];
            op_wdata    = req_wdata;
            op_type     = req_type;
            op_unsigned = req_unsigned;
        end else begin
            op_write    = write_q;
            op_addr     = addr_q;
            op_wdata    = wdata_q;
            op_type     = type_q;
            op_unsigned = unsigned_q;
        end

        word_idx = op_addr[BA_W-1:2];
        rd_word  = mem[word_idx];
        byte_sel = rd_word[{op_addr[1:0], 3'b000} +: 8];
        half_sel = rd_word[{op_addr[1], 4'b0000} +: 16];

        case (op_type)
            2'b00:   op_err = 1'b0;
            2'b01:   op_err = op_addr[0];
            2'b10:   op_err = |op_addr[1:0];
            default: op_err = 1'b1;
        endcase

        case (op_type)
            2'b00: begin
                load_val  = {{(DATA_WIDTH-8){byte_sel[7] & ~op_unsigned}}, byte_sel};
                mem_be    = 4'b0001 << op_addr[1:0];
                mem_wdata = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                load_val  = {{(DATA_WIDTH-16){half_sel[15] & ~op_unsigned}}, half_sel};
                mem_be    = op_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{op_wdata[15:0]}};
            end
            default: begin
                load_val  = rd_word;
                mem_be    = 4'b1111;
                mem_wdata = op_wdata;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM and response next-state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        type_d      = type_q;
        unsigned_d  = unsigned_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    addr_d     = req_addr[BA_W-1:0];
                    wdata_d    = req_wdata;
                    type_d     = req_type;
                    unsigned_d = req_unsigned;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load data is sampled and stores commit on the edge entering RESP.
        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = op_err;
            rsp_rdata_d = (op_err || op_write) ? '0 : load_val;
        end

        mem_we = enter_resp && op_write && !op_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            type_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            type_q      <= type_d;
            unsigned_q  <= unsigned_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Memory has no reset. While reset is low the FSM is held in IDLE, so a
    // store caught mid-transaction never reaches this write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two responders share the request fields, reset and rsp_ready:
//   inst 0 : WAIT_CYCLES = 2
//   inst 1 : WAIT_CYCLES = 0
// Each has its own req_valid, so only one of them is ever addressed. A
// byte-array memory model per instance supplies every expected response.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int BYTES = 4 << AW;
    localparam logic [31:0] MASK = 32'(BYTES - 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared request / response-side inputs ----------------
    logic        req_write    = 1'b0;
    logic [31:0] req_addr     = '0;
    logic [31:0] req_wdata    = '0;
    logic [1:0]  req_type     = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        rsp_ready    = 1'b0;

    // ---------------- per-instance signals ----------------
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_ready_a, req_ready_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        rsp_err_a,   rsp_err_b;
    logic [1:0]  dbg_state_a, dbg_state_b;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid_a),
        .req_ready    (req_ready_a),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_type     (req_type),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid_a),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata_a),
        .rsp_err      (rsp_err_a),
        .dbg_state    (dbg_state_a)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid_b),
        .req_ready    (req_ready_b),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_type     (req_type),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid_b),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata_b),
        .rsp_err      (rsp_err_b),
        .dbg_state    (dbg_state_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  mem_m [2][BYTES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic ready_of(input int inst);
        return (inst == 0) ? req_ready_a : req_ready_b;
    endfunction
    function automatic logic valid_of(input int inst);
        return (inst == 0) ? rsp_valid_a : rsp_valid_b;
    endfunction
    function automatic logic [31:0] rdata_of(input int inst);
        return (inst == 0) ? rsp_rdata_a : rsp_rdata_b;
    endfunction
    function automatic logic err_of(input int inst);
        return (inst == 0) ? rsp_err_a : rsp_err_b;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [1:0] typ, input logic [31:0] addr);
        return (typ == 2'd3) || (typ == 2'd1 && addr[0]) || (typ == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input int inst, input logic [31:0] addr,
                                               input logic [1:0] typ, input logic uns);
        int size = 1 << typ;
        int base = int'(addr & MASK);
        logic [31:0] v = '0;
        for (int b = 0; b < size; b++) v = v | (32'(mem_m[inst][base + b]) << (8 * b));
        if (!uns && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
        return v;
    endfunction

    function automatic void model_store(input int inst, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [1:0] typ);
        int size = 1 << typ;
        int base = int'(addr & MASK);
        for (int b = 0; b < size; b++) mem_m[inst][base + b] = wdata[8 * b +: 8];
    endfunction

    // ---------------- driver ----------------
    task automatic do_txn(input int inst, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] typ,
                          input logic uns, input int hold);
        logic        seen;
        logic        got;
        int          waited;
        int          n;
        logic        exp_e;
        logic [31:0] exp_d;

        exp_e = model_err(typ, addr);
        exp_d = (exp_e || wr) ? 32'd0 : model_load(inst, addr, typ, uns);
        if (wr && !exp_e) model_store(inst, addr, wdata, typ);
        exp_q.push_back(exp_d);

        @(negedge clk);
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wdata;
        req_type     = typ;
        req_unsigned = uns;
        if (inst == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;

        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 20) begin
            if (ready_of(inst)) seen = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check("accept", 32'(seen), 32'd1);
        if (!seen) begin
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);   // acceptance edge

        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // Drop valid and disturb fields; a busy responder must ignore them.
                req_valid_a  = 1'b0;
                req_valid_b  = 1'b0;
                req_write    = 1'($urandom_range(0, 1));
                req_addr     = $urandom();
                req_wdata    = $urandom();
                req_type     = 2'($urandom_range(0, 3));
                req_unsigned = 1'($urandom_range(0, 1));
            end
            if (valid_of(inst)) got = 1'b1;
        end
        check("rsp_seen", 32'(got), 32'd1);
        if (!got) begin
            void'(exp_q.pop_front());
            return;
        end
        check("latency", 32'(n), (inst == 0) ? 32'd3 : 32'd1);
        exp_d = exp_q.pop_front();
        check("rdata", rdata_of(inst), exp_d);
        check("err", 32'(err_of(inst)), 32'(exp_e));

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(valid_of(inst)), 32'd1);
            check("hold_rdata", rdata_of(inst), exp_d);
            check("hold_err", 32'(err_of(inst)), 32'(exp_e));
            check("hold_req_ready", 32'(ready_of(inst)), 32'd0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("retire_valid", 32'(valid_of(inst)), 32'd0);
        check("retire_ready", 32'(ready_of(inst)), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_rdata", rsp_rdata_a, 32'd0);
        check("rst_err", 32'(rsp_err_a), 32'd0);
        check("rst_state", 32'(dbg_state_a), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready_a", 32'(req_ready_a), 32'd1);
        check("rst_ready_b", 32'(req_ready_b), 32'd1);
        check("rst_valid_b", 32'(rsp_valid_b), 32'd0);

        // Give both memories known contents in words 0..31
        for (int inst = 0; inst < 2; inst++)
            for (int w = 0; w < 32; w++)
                do_txn(inst, 1'b1, 32'(w * 4), $urandom(), 2'd2, 1'b0, 0);

        // Word store then load
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);

        // Byte store over a zero word, signed / unsigned / word readback
        do_txn(0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 0);
        do_txn(0, 1'b1, 32'h13, 32'h80, 2'd0, 1'b0, 0);
        do_txn(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0);
        do_txn(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);

        // Error cases, erroneous store leaves word unchanged
        do_txn(0, 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 0);
        do_txn(0, 1'b0, 32'h12, 32'h0, 2'd2, 1'b0, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0);
        do_txn(0, 1'b1, 32'h12, 32'h55AA55AA, 2'd2, 1'b0, 0);
        do_txn(0, 1'b1, 32'h10, 32'h55AA55AA, 2'd3, 1'b0, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);

        // Backpressure: rsp_ready held low for 5 cycles in RESP
        do_txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5);
        do_txn(1, 1'b0, 32'h14, 32'h0, 2'd1, 1'b0, 5);

        // Zero-wait instance, address aliasing
        do_txn(1, 1'b1, 32'h1000, 32'hCAFEF00D, 2'd2, 1'b0, 0);
        do_txn(1, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0);
        do_txn(0, 1'b1, 32'h1004, 32'h0BADF00D, 2'd2, 1'b0, 0);
        do_txn(0, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0, 0);

        // Reset during WAIT of a store: store is discarded
        @(negedge clk);
        req_write    = 1'b1;
        req_addr     = 32'h20;
        req_wdata    = 32'h12345678;
        req_type     = 2'd2;
        req_unsigned = 1'b0;
        req_valid_a  = 1'b1;
        check("abort_ready", 32'(req_ready_a), 32'd1);
        @(negedge clk);
        req_valid_a = 1'b0;
        check("abort_in_wait", 32'(dbg_state_a), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_valid", 32'(rsp_valid_a), 32'd0);
        check("abort_rdata", rsp_rdata_a, 32'd0);
        check("abort_err", 32'(rsp_err_a), 32'd0);
        check("abort_state", 32'(dbg_state_a), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_hold_valid", 32'(rsp_valid_a), 32'd0);
        reset = 1'b1;
        do_txn(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0);

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            a = $urandom() & 32'hFFFF_F07F;   // words 0..31 plus random aliasing bits
            do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom(),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout got=0x%08h exp=0x%08h", n_checks, 32'd0);
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
